kmeans_apb_master: RTL and testbench
====================================

Name: kmeans_apb_master

Overview:
- APB initiator (bus master) that drives the Kmeans accelerator's register/RAM port: psel, penable, pwrite, paddr, pwdata out; pready, prdata, interupt in.
- Converts single commands from a valid/ready command port into APB SETUP/ACCESS transfers and returns the result on a one-cycle response strobe.
- Captures the accelerator's completion interrupt into a sticky pending flag.
- Used as the host-side/test-harness front end driving the accelerator.

Parameters:
- ADDR_WIDTH, 9, APB address width (paddr, cmd_addr).
- DATA_WIDTH, 91, APB data width (pwdata, prdata, cmd_wdata, rsp_rdata).
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit; used only with KMEANS_APB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
- rsp_valid  out  1  one-cycle strobe at transfer completion.
- rsp_write  out  1  echo of the completed command's cmd_write.
- rsp_rdata  out  DATA_WIDTH  prdata captured for reads; 0 for writes.
- rsp_err  out  1  transfer aborted by timeout.
- busy  out  1  high while in SETUP or ACCESS.
- psel, penable, pwrite  out  1  APB controls.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pready  in  1  slave ready.
- prdata  in  DATA_WIDTH  slave read data.
- interupt  in  1  accelerator interrupt, synchronous to clk, level.
- irq_pending  out  1  sticky flag, set on interupt rising edge.
- irq_ack  in  1  clears irq_pending.

Behaviour:
- All outputs are registered. Reset value is 0 for every output except cmd_ready, which is 1 in the first cycle after reset.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1, psel=0, penable=0. On cmd_valid at edge T, latch cmd_write/addr/wdata into pwrite/paddr/pwdata; go to SETUP (cmd_ready=0, psel=1, penable=0 from T+1).
- SETUP: lasts exactly one cycle; then go to ACCESS (psel=1, penable=1).
- ACCESS: hold paddr, pwdata, pwrite stable. At the edge where pready=1, capture prdata (reads only) and go to IDLE: psel=0, penable=0, rsp_valid=1 for one cycle, cmd_ready=1.
- Minimum latency: command accepted at T; SETUP at T+1; ACCESS at T+2; with pready=1 at T+2, rsp_valid and cmd_ready are high at T+3. Next command can be accepted at T+3, giving a 3-cycle issue interval.
- pready is ignored outside ACCESS.
- paddr, pwdata and pwrite hold their last values in IDLE; they are not driven to 0.
- busy = (state != IDLE).
- Interrupt: register interupt_d. irq_pending sets when interupt & !interupt_d; clears on irq_ack. If set and ack occur in the same cycle, set wins. A level held high does not re-set the flag after an ack.
- Reset mid-transfer: at the reset edge the FSM goes to IDLE, psel and penable drop, the transfer is abandoned, no rsp_valid is issued, and irq_pending clears.
- cmd_valid while busy is not accepted; the command must be held until cmd_ready.

Optional Feature:
- Macro: KMEANS_APB_TIMEOUT_EN.
- Defined:
  - A counter resets on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES-1 with pready still 0, the next edge goes to IDLE with psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - pready=1 on the terminal-count cycle completes the transfer normally with rsp_err=0.
- Undefined: no counter; ACCESS waits indefinitely; rsp_err is tied 0.

Test Plan:
- Write, zero wait: cmd write addr=0x005 data=91'h1234, pready=1 always -> psel high 2 cycles, penable high 1 cycle, paddr=0x005, pwdata=0x1234, pwrite=1; rsp_valid 3 cycles after accept with rsp_write=1, rsp_rdata=0.
- Read with 4 wait states: addr=0x1FF, pready low for 4 ACCESS cycles then high with prdata=91'hABCDE -> penable high 5 cycles; rsp_rdata=0xABCDE, rsp_err=0; address held stable throughout.
- Back-to-back: cmd_valid held high for 3 commands -> each accepted only in IDLE, 3-cycle spacing with pready=1, no psel gap shorter than 1 cycle between transfers.
- Interrupt: pulse interupt 1 cycle -> irq_pending=1 next cycle; hold interupt high while asserting irq_ack -> flag clears and stays 0; new rising edge coinciding with irq_ack -> irq_pending remains 1.
- Reset mid-ACCESS: assert rst during wait state -> next cycle psel=0, penable=0, busy=0, cmd_ready=1, no rsp_valid.
- Timeout (KMEANS_APB_TIMEOUT_EN, TIMEOUT_CYCLES=8): pready stuck 0 -> after 8 ACCESS cycles rsp_valid=1, rsp_err=1, rsp_rdata=0, psel drops; without the macro, psel stays high after 100 cycles.

Source files
------------

// File: rtl/kmeans_apb_master_if.sv
// kmeans_apb_master_if
//   APB bus between the kmeans_apb_master initiator and the Kmeans
//   accelerator's register/RAM port.
//
//   Signals:
//     psel, penable, pwrite  initiator -> slave  transfer controls
//     paddr   [ADDR_WIDTH]   initiator -> slave  address
//     pwdata  [DATA_WIDTH]   initiator -> slave  write data
//     pready                 slave -> initiator  ACCESS-phase completion
//     prdata  [DATA_WIDTH]   slave -> initiator  read data
//
//   Modports: master (initiator side), slave (accelerator side).
interface kmeans_apb_master_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 91
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata
    );
endinterface

// File: rtl/kmeans_apb_master.sv
// kmeans_apb_master
//   APB initiator for the Kmeans accelerator. Single commands taken on a
//   valid/ready port become one APB SETUP/ACCESS transfer each; completion is
//   reported on a one-cycle response strobe. The accelerator's interrupt is
//   captured into a sticky pending flag.
//
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     cmd_valid/cmd_ready           command handshake
//     cmd_write, cmd_addr, cmd_wdata command contents
//     rsp_valid                     one-cycle completion strobe
//     rsp_write, rsp_rdata, rsp_err completion echo, read data, timeout flag
//     busy                          transfer in progress (SETUP or ACCESS)
//     apb                           APB bus (kmeans_apb_master_if.master)
//     interupt                      accelerator interrupt (level, synchronous)
//     irq_pending, irq_ack          sticky interrupt flag and its clear
//
//   Optional feature: define KMEANS_APB_TIMEOUT_EN to abort an ACCESS phase
//   that has not seen pready after TIMEOUT_CYCLES cycles (rsp_err=1).
//   Without it the ACCESS phase waits indefinitely and rsp_err stays 0.
module kmeans_apb_master #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 91,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    kmeans_apb_master_if.master   apb,
    input  logic                  interupt,
    output logic                  irq_pending,
    input  logic                  irq_ack
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("kmeans_apb_master: TIMEOUT_CYCLES must be at least 2");
    end

    state_t                state, state_next;
    logic                  psel, penable, pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  interupt_d;
    logic                  tmo_hit;

    logic                  cmd_ready_next, psel_next, penable_next, pwrite_next;
    logic [ADDR_WIDTH-1:0] paddr_next;
    logic [DATA_WIDTH-1:0] pwdata_next;
    logic                  rsp_valid_next, rsp_write_next, rsp_err_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_next;

    assign apb.psel    = psel;
    assign apb.penable = penable;
    assign apb.pwrite  = pwrite;
    assign apb.paddr   = paddr;
    assign apb.pwdata  = pwdata;

`ifdef KMEANS_APB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_cnt;

    // Counts ACCESS cycles without pready; cleared while in SETUP so every
    // ACCESS phase starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !apb.pready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == ACCESS) && !apb.pready &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_next     = state;
        cmd_ready_next = cmd_ready;
        psel_next      = psel;
        penable_next   = penable;
        pwrite_next    = pwrite;
        paddr_next     = paddr;
        pwdata_next    = pwdata;
        rsp_valid_next = 1'b0;
        rsp_write_next = rsp_write;
        rsp_rdata_next = rsp_rdata;
        rsp_err_next   = rsp_err;
        unique case (state)
            IDLE: begin
                cmd_ready_next = 1'b1;
                psel_next      = 1'b0;
                penable_next   = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    state_next     = SETUP;
                    cmd_ready_next = 1'b0;
                    psel_next      = 1'b1;
                    pwrite_next    = cmd_write;
                    paddr_next     = cmd_addr;
                    pwdata_next    = cmd_wdata;
                end
            end
            SETUP: begin
                state_next   = ACCESS;
                penable_next = 1'b1;
            end
            ACCESS: begin
                // A completion without pready can only be a timeout abort.
                if (apb.pready || tmo_hit) begin
                    state_next     = IDLE;
                    cmd_ready_next = 1'b1;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_write_next = pwrite;
                    rsp_err_next   = !apb.pready;
                    rsp_rdata_next = (pwrite || !apb.pready) ? '0 : apb.prdata;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            interupt_d  <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            state       <= state_next;
            cmd_ready   <= cmd_ready_next;
            psel        <= psel_next;
            penable     <= penable_next;
            pwrite      <= pwrite_next;
            paddr       <= paddr_next;
            pwdata      <= pwdata_next;
            rsp_valid   <= rsp_valid_next;
            rsp_write   <= rsp_write_next;
            rsp_rdata   <= rsp_rdata_next;
            rsp_err     <= rsp_err_next;
            busy        <= (state_next != IDLE);
            interupt_d  <= interupt;
            // A new rising edge wins over a simultaneous ack.
            irq_pending <= (interupt && !interupt_d) || (irq_pending && !irq_ack);
        end
    end
endmodule

// File: tb/tb_kmeans_apb_master.sv
module tb_kmeans_apb_master;
    localparam int AW  = 9;
    localparam int DW  = 91;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_write, rsp_err, busy;
    logic [DW-1:0] rsp_rdata;
    logic          interupt, irq_pending, irq_ack;

    kmeans_apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    kmeans_apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .apb(apb),
        .interupt(interupt), .irq_pending(irq_pending), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          w;
        logic [DW-1:0] rd;
        logic          err;
    } exp_t;

    exp_t          sb_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            wait_states = 0;
    logic [DW-1:0] slave_rdata = '0;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // APB slave: pready held low for wait_states ACCESS cycles, then high.
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        apb.pready = 1'b1;
        apb.prdata = '0;
        forever begin
            @(negedge clk);
            apb.prdata = slave_rdata;
            if (apb.psel && apb.penable) begin
                if (acc_cnt < wait_states) begin
                    apb.pready = 1'b0;
                    acc_cnt++;
                end else begin
                    apb.pready = 1'b1;
                end
            end else begin
                apb.pready = 1'b1;
                acc_cnt = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response strobe appears.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
            end else begin
                e = sb_q.pop_front();
                check("rsp_write", DW'(rsp_write), DW'(e.w));
                check("rsp_rdata", rsp_rdata, e.rd);
                check("rsp_err", DW'(rsp_err), DW'(e.err));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] rd, input logic err, output time t_acc);
        exp_t e;
        int   n;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        t_acc = 0;
        if (!cmd_ready) begin
            check("cmd_accept_timeout", DW'(cmd_ready), DW'(1));
        end else begin
            e.w   = w;
            e.rd  = w ? '0 : rd;
            e.err = err;
            sb_q.push_back(e);
            @(posedge clk);
            t_acc = $time;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic observe(input int maxc, output int ps, output int pe, output int lat,
                           output bit stable, output logic [AW-1:0] a0,
                           output logic [DW-1:0] d0, output logic w0);
        ps = 0; pe = 0; lat = -1; stable = 1'b1;
        a0 = apb.paddr; d0 = apb.pwdata; w0 = apb.pwrite;
        for (int k = 1; k <= maxc; k++) begin
            if (apb.psel) begin
                ps++;
                if (apb.paddr !== a0 || apb.pwdata !== d0 || apb.pwrite !== w0) stable = 1'b0;
            end
            if (apb.penable) pe++;
            if (rsp_valid && lat < 0) lat = k;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time           t0, t1, t2;
        int            ps, pe, lat, cnt;
        bit            stable;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          w0;

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        interupt = 1'b0; irq_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Reset state
        check("reset_cmd_ready", DW'(cmd_ready), DW'(1));
        check("reset_psel", DW'(apb.psel), DW'(0));
        check("reset_penable", DW'(apb.penable), DW'(0));
        check("reset_busy", DW'(busy), DW'(0));
        check("reset_rsp_valid", DW'(rsp_valid), DW'(0));
        check("reset_irq_pending", DW'(irq_pending), DW'(0));

        // Write, zero wait states
        wait_states = 0;
        issue(1'b1, 9'h005, 91'h1234, '0, 1'b0, t0);
        observe(6, ps, pe, lat, stable, a0, d0, w0);
        check("wr_psel_cycles", DW'(ps), DW'(2));
        check("wr_penable_cycles", DW'(pe), DW'(1));
        check("wr_latency", DW'(lat), DW'(3));
        check("wr_paddr", DW'(a0), DW'(9'h005));
        check("wr_pwdata", d0, 91'h1234);
        check("wr_pwrite", DW'(w0), DW'(1));
        check("wr_stable", DW'(stable), DW'(1));

        // Read with 4 wait states
        wait_states = 4;
        slave_rdata = 91'hABCDE;
        issue(1'b0, 9'h1FF, 91'h0, 91'hABCDE, 1'b0, t0);
        observe(10, ps, pe, lat, stable, a0, d0, w0);
        check("rd_psel_cycles", DW'(ps), DW'(6));
        check("rd_penable_cycles", DW'(pe), DW'(5));
        check("rd_latency", DW'(lat), DW'(7));
        check("rd_paddr", DW'(a0), DW'(9'h1FF));
        check("rd_pwrite", DW'(w0), DW'(0));
        check("rd_stable", DW'(stable), DW'(1));
        check("idle_paddr_held", DW'(apb.paddr), DW'(9'h1FF));

        // Back-to-back commands with cmd_valid held
        wait_states = 0;
        slave_rdata = 91'h5A5A;
        issue(1'b1, 9'h010, 91'h111, '0, 1'b0, t0);
        issue(1'b0, 9'h020, 91'h0, 91'h5A5A, 1'b0, t1);
        issue(1'b1, 9'h030, 91'h333, '0, 1'b0, t2);
        check("b2b_gap_1", DW'(t1 - t0), DW'(30));
        check("b2b_gap_2", DW'(t2 - t1), DW'(30));
        repeat (4) @(negedge clk);
        check("b2b_last_paddr", DW'(apb.paddr), DW'(9'h030));

        // Interrupt capture
        interupt = 1'b1;
        @(negedge clk);
        check("irq_set", DW'(irq_pending), DW'(1));
        interupt = 1'b0;
        @(negedge clk);
        check("irq_sticky", DW'(irq_pending), DW'(1));
        interupt = 1'b1;
        @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        check("irq_ack_clear", DW'(irq_pending), DW'(0));
        irq_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("irq_level_no_reset", DW'(irq_pending), DW'(0));
        interupt = 1'b0;
        @(negedge clk);
        interupt = 1'b1;
        @(negedge clk);
        check("irq_set_again", DW'(irq_pending), DW'(1));
        interupt = 1'b0;
        @(negedge clk);
        interupt = 1'b1;
        irq_ack = 1'b1;
        @(negedge clk);
        check("irq_set_wins", DW'(irq_pending), DW'(1));
        interupt = 1'b0;
        irq_ack = 1'b1;
        @(negedge clk);
        check("irq_ack_only", DW'(irq_pending), DW'(0));
        irq_ack = 1'b0;

        // Reset in the middle of an ACCESS wait
        interupt = 1'b1;
        @(negedge clk);
        interupt = 1'b0;
        wait_states = 50;
        issue(1'b0, 9'h0AA, 91'h0, 91'h5A5A, 1'b0, t0);
        repeat (3) @(negedge clk);
        check("mid_access_penable", DW'(apb.penable), DW'(1));
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("rst_psel", DW'(apb.psel), DW'(0));
        check("rst_penable", DW'(apb.penable), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_cmd_ready", DW'(cmd_ready), DW'(1));
        check("rst_irq_pending", DW'(irq_pending), DW'(0));
        rst = 1'b0;
        wait_states = 0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid) cnt++;
            @(negedge clk);
        end
        check("rst_no_rsp", DW'(cnt), DW'(0));

        // Slave that never answers
        wait_states = 100000;
`ifdef KMEANS_APB_TIMEOUT_EN
        issue(1'b0, 9'h077, 91'h0, '0, 1'b1, t0);
        observe(12, ps, pe, lat, stable, a0, d0, w0);
        check("tmo_penable_cycles", DW'(pe), DW'(TMO));
        check("tmo_latency", DW'(lat), DW'(TMO + 2));
        check("tmo_psel_dropped", DW'(apb.psel), DW'(0));
`else
        issue(1'b0, 9'h077, 91'h0, '0, 1'b0, t0);
        repeat (100) @(negedge clk);
        check("stuck_psel", DW'(apb.psel), DW'(1));
        check("stuck_penable", DW'(apb.penable), DW'(1));
        check("stuck_rsp_err", DW'(rsp_err), DW'(0));
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
`endif
        wait_states = 0;
        repeat (4) @(negedge clk);
        check("scoreboard_drained", DW'(sb_q.size()), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
